// File: rtl/peecc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peecc_ctrl_pkg
// Description : Shared definitions for the PEECC run controller:
//               - controller state encoding;
//               - activity shift-register tap indices for each stage enable;
//               - default counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package peecc_ctrl_pkg;

    // Controller state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_DONE   = 3'd3,
        ST_REPORT = 3'd4,
        ST_HOLD   = 3'd5
    } ctrl_state_t;

    // Activity shift-register taps feeding each DataPath stage enable
    localparam int TAP_GEN   = 0;
    localparam int TAP_ENC   = 1;
    localparam int TAP_BUS   = 2;
    localparam int TAP_DEC   = 3;
    localparam int TAP_TRANS = 3;
    localparam int TAP_KCOMP = 4;

    // Default width of the sample and error counters
    localparam int CNT_W_DEFAULT = 11;

endpackage : peecc_ctrl_pkg
`default_nettype wire

// File: rtl/peecc_stage_shifter.sv
`default_nettype none
// ============================================================================
// Module      : peecc_stage_shifter
// Description : Activity shift register. taps[0] is din delayed by one clock,
//               taps[i] is din delayed by i+1 clocks. Synchronous active-high
//               clear.
// Ports       : clk  in  1      rising-edge clock
//               clr  in  1      synchronous clear, active high
//               din  in  1      activity bit shifted into tap 0
//               taps out WIDTH  all register taps
// Revision    : 1.0 - initial release
// ============================================================================
module peecc_stage_shifter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             din,
    output logic [WIDTH-1:0] taps
);

    logic [WIDTH-1:0] taps_q;
    logic [WIDTH-1:0] taps_d;

    always_comb begin
        taps_d = {taps_q[WIDTH-2:0], din};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign taps = taps_q;

endmodule : peecc_stage_shifter
`default_nettype wire

// File: rtl/peecc_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : peecc_run_controller
// Description : Test-run sequencer upstream of the PEECC DataPath. Produces
//               staggered stage enables for one run of NUM_SAMPLES words,
//               checks isequal over the aligned compare window, pulses done
//               and captures the DataPath statistics.
//               Optional feature macro: PEECC_STOP_ON_ERR_EN - when defined,
//               the first mismatch seen during RUN ends the run early.
// Ports       : clk, rst (sync, active high), start, isequal,
//               max_reg[4:0], sum_transitions[21:0]               (inputs)
//               en_gen_data, en_enc, en_bus, en_dec, en_trans_count,
//               en_k_comp, done, busy, finished,
//               err_cnt[CNT_W-1:0], first_err_idx[CNT_W-1:0],
//               res_max_reg[4:0], res_sum[21:0]                   (outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module peecc_run_controller
    import peecc_ctrl_pkg::*;
#(
    parameter int NUM_SAMPLES = 1024,
    parameter int COMP_LAT    = 5,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             isequal,
    input  logic [4:0]       max_reg,
    input  logic [21:0]      sum_transitions,
    output logic             en_gen_data,
    output logic             en_enc,
    output logic             en_bus,
    output logic             en_trans_count,
    output logic             en_dec,
    output logic             en_k_comp,
    output logic             done,
    output logic             busy,
    output logic             finished,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [4:0]       res_max_reg,
    output logic [21:0]      res_sum
);

    localparam logic [CNT_W-1:0] C_LAST_SAMPLE = CNT_W'(NUM_SAMPLES - 1);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] widx_q, widx_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] first_err_q, first_err_d;
    logic             have_err_q, have_err_d;
    logic [4:0]       res_max_q, res_max_d;
    logic [21:0]      res_sum_q, res_sum_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             finished_q, finished_d;

    logic [COMP_LAT:0] sr;
    logic              act;
    logic              cmp_v;
    logic              mismatch;
    logic              drain_empty;

    assign act      = (state_q == ST_RUN);
    assign cmp_v    = sr[COMP_LAT];
    assign mismatch = cmp_v & ~isequal;
    // Last compare cycle: only the window tap is still occupied, so the next
    // edge retires the final word and the DataPath is empty.
    assign drain_empty = (sr[COMP_LAT-1:0] == '0);

    peecc_stage_shifter #(
        .WIDTH (COMP_LAT + 1)
    ) u_shifter (
        .clk  (clk),
        .clr  (rst),
        .din  (act),
        .taps (sr)
    );

    always_comb begin
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        widx_d      = widx_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        have_err_d  = have_err_q;
        res_max_d   = res_max_q;
        res_sum_d   = res_sum_q;

        // Window statistics run independently of state: words still in
        // flight after RUN ends are compared during DRAIN.
        if (cmp_v) begin
            widx_d = widx_q + 1'b1;
            if (!isequal) begin
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                if (!have_err_q) begin
                    first_err_d = widx_q;
                    have_err_d  = 1'b1;
                end
            end
        end

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (start) begin
                    state_d     = ST_RUN;
                    run_cnt_d   = '0;
                    widx_d      = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    have_err_d  = 1'b0;
                    res_max_d   = '0;
                    res_sum_d   = '0;
                end
            end
            ST_RUN: begin
                run_cnt_d = run_cnt_q + 1'b1;
                if (run_cnt_q == C_LAST_SAMPLE) begin
                    state_d = ST_DRAIN;
                end
`ifdef PEECC_STOP_ON_ERR_EN
                if (mismatch && !have_err_q) begin
                    state_d = ST_DRAIN;
                end
`endif
            end
            ST_DRAIN: begin
                if (drain_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                // DataPath registers its statistics on the done edge, so they
                // are stable for the whole REPORT cycle.
                res_max_d = max_reg;
                res_sum_d = sum_transitions;
                state_d   = ST_HOLD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // exactly with the state they describe.
        done_d     = (state_d == ST_DONE);
        busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN) ||
                     (state_d == ST_DONE);
        finished_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            run_cnt_q   <= '0;
            widx_q      <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            have_err_q  <= 1'b0;
            res_max_q   <= '0;
            res_sum_q   <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            widx_q      <= widx_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            have_err_q  <= have_err_d;
            res_max_q   <= res_max_d;
            res_sum_q   <= res_sum_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            finished_q  <= finished_d;
        end
    end

    assign en_gen_data    = sr[TAP_GEN];
    assign en_enc         = sr[TAP_ENC];
    assign en_bus         = sr[TAP_BUS];
    assign en_dec         = sr[TAP_DEC];
    assign en_trans_count = sr[TAP_TRANS];
    assign en_k_comp      = sr[TAP_KCOMP];
    assign done           = done_q;
    assign busy           = busy_q;
    assign finished       = finished_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_idx  = first_err_q;
    assign res_max_reg    = res_max_q;
    assign res_sum        = res_sum_q;

endmodule : peecc_run_controller
`default_nettype wire

// File: tb/tb_peecc_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_peecc_run_controller
// Description : Self-checking bench for peecc_run_controller with
//               NUM_SAMPLES=8, COMP_LAT=5. Table-driven runs, randomized runs
//               and a mid-run reset sequence, checked against a cycle-level
//               expectation derived from the run timeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peecc_run_controller;

    localparam int N = 8;
    localparam int L = 5;
    localparam int W = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          isequal;
    logic [4:0]    max_reg;
    logic [21:0]   sum_transitions;
    logic          en_gen_data, en_enc, en_bus, en_trans_count, en_dec, en_k_comp;
    logic          done, busy, finished;
    logic [W-1:0]  err_cnt, first_err_idx;
    logic [4:0]    res_max_reg;
    logic [21:0]   res_sum;

    int tests = 0;
    int fails = 0;

    peecc_run_controller #(
        .NUM_SAMPLES (N),
        .COMP_LAT    (L),
        .CNT_W       (W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .isequal         (isequal),
        .max_reg         (max_reg),
        .sum_transitions (sum_transitions),
        .en_gen_data     (en_gen_data),
        .en_enc          (en_enc),
        .en_bus          (en_bus),
        .en_trans_count  (en_trans_count),
        .en_dec          (en_dec),
        .en_k_comp       (en_k_comp),
        .done            (done),
        .busy            (busy),
        .finished        (finished),
        .err_cnt         (err_cnt),
        .first_err_idx   (first_err_idx),
        .res_max_reg     (res_max_reg),
        .res_sum         (res_sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   mask;    // window indices where isequal is driven low
        logic [31:0]  noise;   // cycles with a spurious start pulse
        logic [4:0]   mr;
        logic [21:0]  sum;
        logic [W-1:0] e_err;
        logic [W-1:0] e_first;
    } vec_t;

    task automatic chk(input string name, input int c, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, exp);
        end
    endtask

    function automatic logic [8:0] ctrl_vec();
        return {en_gen_data, en_enc, en_bus, en_dec, en_trans_count, en_k_comp,
                done, busy, finished};
    endfunction

    // Expected control outputs in cycle c of a run whose start was sampled at
    // edge 0: stage k is enabled for cycles k+1..k+N; done follows the last
    // compare by one cycle; finished begins once results are latched.
    function automatic logic [8:0] exp_ctrl(input int c);
        logic [8:0] v;
        v[8] = (c >= 1) && (c <= N);
        v[7] = (c >= 2) && (c <= N + 1);
        v[6] = (c >= 3) && (c <= N + 2);
        v[5] = (c >= 4) && (c <= N + 3);
        v[4] = (c >= 4) && (c <= N + 3);
        v[3] = (c >= 5) && (c <= N + 4);
        v[2] = (c == N + L + 1);
        v[1] = (c >= 0) && (c <= N + L + 1);
        v[0] = (c >= N + L + 3);
        return v;
    endfunction

    // Applies one run from IDLE/HOLD and checks it cycle by cycle.
    task automatic run_one(input string name, input vec_t v);
        int idx;
        start   = 1'b1;
        isequal = 1'b1;
        for (int c = 0; c <= N + L + 4; c++) begin
            @(posedge clk);
            #1;
            start = v.noise[c];
            idx   = c - (L + 1);
            isequal = !((idx >= 0) && (idx < N) && v.mask[idx]);
            if (c >= N + L + 1) begin
                max_reg         = v.mr;
                sum_transitions = v.sum;
            end else begin
                max_reg         = 5'($urandom);
                sum_transitions = 22'($urandom);
            end
            chk({name, "_ctrl"}, c, 64'(ctrl_vec()), 64'(exp_ctrl(c)));
        end
        chk({name, "_err_cnt"}, N + L + 4, 64'(err_cnt), 64'(v.e_err));
        chk({name, "_first_err"}, N + L + 4, 64'(first_err_idx), 64'(v.e_first));
        chk({name, "_res_max"}, N + L + 4, 64'(res_max_reg), 64'(v.mr));
        chk({name, "_res_sum"}, N + L + 4, 64'(res_sum), 64'(v.sum));
    endtask

    vec_t tbl[5];
    vec_t rv;

    initial begin
        tbl[0] = '{8'h00, 32'h0, 5'd9,  22'h00ABC,  11'd0, 11'd0};
        tbl[1] = '{8'h24, 32'h0, 5'd3,  22'h3FFFFF, 11'd2, 11'd2};
        tbl[2] = '{8'h80, 32'h0, 5'd31, 22'h000001, 11'd1, 11'd7};
        tbl[3] = '{8'hFF, 32'h0000_9224, 5'd0, 22'h12345, 11'd8, 11'd0};
        tbl[4] = '{8'h01, 32'h0000_0102, 5'd17, 22'h00000, 11'd1, 11'd0};

        rst = 1'b1;
        start = 1'b0;
        isequal = 1'b1;
        max_reg = '0;
        sum_transitions = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("reset_ctrl", 0, 64'(ctrl_vec()), 64'd0);
        chk("reset_stats", 0, 64'({err_cnt, first_err_idx, res_max_reg, res_sum}), 64'd0);

        // Table-driven runs
        for (int t = 0; t < 5; t++) begin
            run_one($sformatf("tbl%0d", t), tbl[t]);
        end

        // Randomized runs: expectation computed from the mismatch mask
        for (int r = 0; r < 8; r++) begin
            int cnt;
            int first;
            rv.mask  = 8'($urandom);
            rv.noise = $urandom & 32'h0000_FFFE;
            rv.mr    = 5'($urandom);
            rv.sum   = 22'($urandom);
            cnt   = 0;
            first = -1;
            for (int i = 0; i < N; i++) begin
                if (rv.mask[i]) begin
                    cnt++;
                    if (first < 0) first = i;
                end
            end
            rv.e_err   = W'(cnt);
            rv.e_first = (first < 0) ? '0 : W'(first);
            run_one($sformatf("rnd%0d", r), rv);
        end

        // Mid-run reset: outputs clear on the next cycle, then a clean run
        start = 1'b1;
        isequal = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        isequal = 1'b1;
        chk("midrst_ctrl", 0, 64'(ctrl_vec()), 64'd0);
        chk("midrst_stats", 0, 64'({err_cnt, first_err_idx, res_max_reg, res_sum}), 64'd0);
        @(posedge clk);
        #1;
        chk("midrst_idle", 1, 64'(ctrl_vec()), 64'd0);
        run_one("after_rst", tbl[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_peecc_run_controller
`default_nettype wire
